// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM encoding for the write-only SPI controller.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TICK_W  = 8;
    localparam int BIT_W   = 4;

    localparam logic WRITE_BIT = 1'b1;

    // Peripheral register map; other addresses are still sent, the peripheral drops them.
    localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] a,
                                                       input logic [DATA_W-1:0] d);
        return {WRITE_BIT, a, d};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: one-cycle tick every `period` clk cycles while enabled; restarts from zero on request.
module spi_tick_gen
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == period - TICK_W'(1));

    // NOTE: cnt_d gets a value on every path before any condition, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + TICK_W'(1);
        if (!en || restart || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only master: sends {1, addr[6:0], data[7:0]} MSB first, one frame per accepted start.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              done,
    output logic              sclk,
    output logic              ncs,
    output logic              copi
);

    localparam logic [TICK_W-1:0] DIV_T    = TICK_W'(CLK_DIV);
    localparam logic [TICK_W-1:0] GAP_T    = TICK_W'(GAP_CYCLES);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_W - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 ncs_q, ncs_d;
    logic                 done_q, done_d;

    logic                 tick;
    logic                 tick_en;
    logic                 tick_restart;
    logic [TICK_W-1:0]    tick_period;
    logic                 accept;

    assign ready        = (state_q == ST_IDLE) && !rst;
    assign accept       = start && ready;
    assign tick_en      = (state_q != ST_IDLE);
    assign tick_restart = (state_d != state_q);
    assign tick_period  = (state_q == ST_GAP) ? GAP_T : DIV_T;

    spi_tick_gen u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (tick_en),
        .restart (tick_restart),
        .period  (tick_period),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SETUP;
                    shift_d   = build_frame(addr, data);
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: if (tick) state_d = ST_HIGH;
            ST_HIGH: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Shift on the falling sclk edge so copi is stable across the next rise.
                        state_d   = ST_LOW;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            ST_LOW: if (tick) state_d = ST_HIGH;
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_GAP;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            ST_GAP: if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus pins are registered from the next state so they switch with the FSM, glitch-free.
        sclk_d = (state_d == ST_HIGH);
        ncs_d  = !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            done_q    <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign ncs  = ncs_q;
    assign copi = shift_q[FRAME_W-1];
    assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with a behavioural mode-0 peripheral decoding the bus.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 4;
    localparam int NCS_LOW    = 33 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready, done, sclk, ncs, copi;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_controller #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .addr  (addr),
        .data  (data),
        .ready (ready),
        .done  (done),
        .sclk  (sclk),
        .ncs   (ncs),
        .copi  (copi)
    );

    // Peripheral model and bus monitor, sampled on clk so each edge sees the previous cycle.
    logic               per_rst;
    logic [DATA_W-1:0]  per_regs [0:7];
    logic [FRAME_W-1:0] sh = '0;
    logic [FRAME_W-1:0] last_frame = '0;
    logic [FRAME_W-1:0] prev_frame = '0;
    logic               sclk_prev, copi_prev, ncs_prev;
    int nbits = 0, last_nbits = 0, rise_cnt = 0, done_cnt = 0, frame_cnt = 0;
    int lo_run = 0, hi_run = 0, last_low = 0, last_gap = 0, violations = 0;

    always @(posedge clk) begin
        sclk_prev <= sclk;
        copi_prev <= copi;
        ncs_prev  <= ncs;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (sclk_prev === 1'b1 && sclk === 1'b1 && copi !== copi_prev) violations <= violations + 1;
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            rise_cnt <= rise_cnt + 1;
            if (ncs !== 1'b0) begin
                violations <= violations + 1;
            end else begin
                sh    <= {sh[FRAME_W-2:0], copi};
                nbits <= nbits + 1;
            end
        end
        if (ncs === 1'b1) begin
            hi_run <= hi_run + 1;
            if (ncs_prev === 1'b0) begin
                last_frame <= sh;
                prev_frame <= last_frame;
                last_nbits <= nbits;
                last_low   <= lo_run;
                frame_cnt  <= frame_cnt + 1;
                lo_run     <= 0;
                sh         <= '0;
                nbits      <= 0;
                if (nbits == FRAME_W && sh[15] && sh[14:8] <= PWM_DUTY) per_regs[sh[10:8]] <= sh[7:0];
            end
        end else if (ncs === 1'b0) begin
            lo_run <= lo_run + 1;
            if (ncs_prev === 1'b1) begin
                last_gap <= hi_run;
                hi_run   <= 0;
            end
        end
        if (per_rst) begin
            for (int i = 0; i < 8; i++) per_regs[i] <= '0;
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = (ready === 1'b1);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        start = 1'b1;
        addr  = a;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        addr  = ~a;
        data  = ~d;
    endtask

    task automatic wait_done(input int base, output bit ok);
        int t = 0;
        while (done_cnt <= base && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = (done_cnt > base);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; addr = '0; data = '0; per_rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ncs, sclk, copi, done, ready} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs: ncs/sclk/copi/done/ready got %b expected 10000",
                     {ncs, sclk, copi, done, ready});
        end
        rst = 1'b0; per_rst = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b expected 1", ready);
        end
        @(negedge clk);
        vectors++;
        if (ncs !== 1'b1 || sclk !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_bus: ncs=%b sclk=%b expected ncs=1 sclk=0", ncs, sclk);
        end
    endtask

    task automatic test_frame_0480;
        int d0 = done_cnt;
        bit ok;
        wait_ready(ok);
        issue(PWM_DUTY, 8'h80);
        vectors++;
        if (ncs !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_cycle: ncs=%b ready=%b expected 0 0", ncs, ready);
        end
        wait_done(d0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL frame_0480_done: timeout, no done pulse"); end
        vectors++;
        if (last_frame !== 16'h8480) begin
            miscompares++;
            $display("FAIL frame_0480_bits: got %h expected 8480", last_frame);
        end
        vectors++;
        if (last_nbits != 16) begin
            miscompares++;
            $display("FAIL frame_0480_edges: got %0d expected 16", last_nbits);
        end
        vectors++;
        if (last_low != NCS_LOW) begin
            miscompares++;
            $display("FAIL frame_0480_ncs_low: got %0d expected %0d", last_low, NCS_LOW);
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL frame_0480_done_width: got %0d done cycles expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_loopback;
        bit ok;
        int d0 = done_cnt;
        wait_ready(ok);
        issue(EN_OUT_7_0, 8'hA5);
        wait_done(d0, ok);
        wait_ready(ok);
        issue(PWM_DUTY, 8'h3C);
        wait_done(d0 + 1, ok);
        vectors++;
        if (per_regs[EN_OUT_7_0[2:0]] !== 8'hA5) begin
            miscompares++;
            $display("FAIL loop_en_out_7_0: got %h expected a5", per_regs[EN_OUT_7_0[2:0]]);
        end
        vectors++;
        if (per_regs[PWM_DUTY[2:0]] !== 8'h3C) begin
            miscompares++;
            $display("FAIL loop_pwm_duty: got %h expected 3c", per_regs[PWM_DUTY[2:0]]);
        end
        vectors++;
        if ({per_regs[1], per_regs[2], per_regs[3]} !== 24'h0) begin
            miscompares++;
            $display("FAIL loop_others: got %h %h %h expected 00 00 00",
                     per_regs[1], per_regs[2], per_regs[3]);
        end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2, ok;
        int d0 = done_cnt;
        int f0 = frame_cnt;
        int t = 0;
        wait_ready(ok);
        start = 1'b1; addr = EN_OUT_15_8; data = 8'h11;
        @(negedge clk);
        addr = EN_PWM_7_0; data = 8'h22;
        wait_done(d0, ok1);
        while (ncs !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0; addr = '0; data = '0;
        wait_done(d0 + 1, ok2);
        repeat (60) @(negedge clk);
        vectors++;
        if (!ok1 || !ok2) begin
            miscompares++;
            $display("FAIL b2b_done: got done1=%b done2=%b expected 1 1", ok1, ok2);
        end
        vectors++;
        if (prev_frame !== 16'h8111 || last_frame !== 16'h8222) begin
            miscompares++;
            $display("FAIL b2b_frames: got %h %h expected 8111 8222", prev_frame, last_frame);
        end
        vectors++;
        if (last_gap != GAP_CYCLES + 1) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d expected %0d", last_gap, GAP_CYCLES + 1);
        end
        vectors++;
        if (frame_cnt - f0 != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d frames expected 2", frame_cnt - f0);
        end
        vectors++;
        if (per_regs[1] !== 8'h11 || per_regs[2] !== 8'h22) begin
            miscompares++;
            $display("FAIL b2b_regs: got %h %h expected 11 22", per_regs[1], per_regs[2]);
        end
    endtask

    task automatic test_busy_ignored;
        bit ok;
        int d0 = done_cnt;
        int f0 = frame_cnt;
        wait_ready(ok);
        issue(EN_PWM_15_8, 8'h77);
        repeat (40) @(negedge clk);
        start = 1'b1; addr = EN_PWM_7_0; data = 8'h99;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, ok);
        repeat (150) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 1 || frame_cnt - f0 != 1) begin
            miscompares++;
            $display("FAIL busy_counts: got done=%0d frames=%0d expected 1 1",
                     done_cnt - d0, frame_cnt - f0);
        end
        vectors++;
        if (last_frame !== 16'h8377 || per_regs[3] !== 8'h77 || per_regs[2] !== 8'h22) begin
            miscompares++;
            $display("FAIL busy_data: got frame=%h r3=%h r2=%h expected 8377 77 22",
                     last_frame, per_regs[3], per_regs[2]);
        end
    endtask

    task automatic test_abort;
        bit ok;
        int d0 = done_cnt;
        int r0 = rise_cnt;
        int t = 0;
        wait_ready(ok);
        issue(EN_OUT_7_0, 8'h5A);
        while (rise_cnt - r0 < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ncs !== 1'b1 || sclk !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_bus: ncs=%b sclk=%b expected 1 0", ncs, sclk);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (done_cnt != d0 || last_nbits != 5) begin
            miscompares++;
            $display("FAIL abort_frame: got done=%0d bits=%0d expected 0 5", done_cnt - d0, last_nbits);
        end
        vectors++;
        if (per_regs[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL abort_regs: got %h expected a5", per_regs[0]);
        end
        d0 = done_cnt;
        wait_ready(ok);
        issue(EN_OUT_7_0, 8'h66);
        wait_done(d0, ok);
        vectors++;
        if (!ok || last_frame !== 16'h8066 || per_regs[0] !== 8'h66) begin
            miscompares++;
            $display("FAIL abort_recover: got done=%b frame=%h r0=%h expected 1 8066 66",
                     ok, last_frame, per_regs[0]);
        end
    endtask

    task automatic test_bad_addr;
        bit ok;
        int d0 = done_cnt;
        logic [DATA_W-1:0] exp_regs [0:4];
        exp_regs[0] = 8'h66; exp_regs[1] = 8'h11; exp_regs[2] = 8'h22;
        exp_regs[3] = 8'h77; exp_regs[4] = 8'h3C;
        wait_ready(ok);
        issue(7'h05, 8'hFF);
        wait_done(d0, ok);
        vectors++;
        if (!ok || last_frame !== 16'h85FF || last_nbits != 16 || last_low != NCS_LOW) begin
            miscompares++;
            $display("FAIL bad_addr_frame: got done=%b frame=%h bits=%0d low=%0d expected 1 85ff 16 %0d",
                     ok, last_frame, last_nbits, last_low, NCS_LOW);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (per_regs[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL bad_addr_reg%0d: got %h expected %h", i, per_regs[i], exp_regs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_0480();
        test_loopback();
        test_back_to_back();
        test_busy_ignored();
        test_abort();
        test_bad_addr();
        vectors++;
        if (violations != 0) begin
            miscompares++;
            $display("FAIL bus_protocol: got %0d violations expected 0", violations);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 4..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: minimum clk cycles ncs stays high between frames; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to send one write frame.
REQ-006 The block SHALL have port addr, input, 7 bits: register address placed in frame bits [14:8].
REQ-007 The block SHALL have port data, input, 8 bits: write data placed in frame bits [7:0].
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE; request accepted when start and ready are both high.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse on completion of a frame.
REQ-010 The block SHALL have ports sclk, ncs and copi, output, 1 bit each: serial clock, active-low chip-select and serial data to the peripheral.

Function
REQ-011 Frame format SHALL be 16 bits, MSB first: bit15 = 1 (write), bits[14:8] = addr, bits[7:0] = data.
REQ-012 The frame SHALL be captured into a shift register on the accepting clk edge; later changes to addr or data SHALL NOT affect the frame in flight.
REQ-013 The bus SHALL use SPI mode 0: sclk idles low, copi changes only while sclk is low, and the peripheral samples copi on the sclk rising edge.
REQ-014 The FSM SHALL have states IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-015 IDLE -> SETUP on accept; ncs SHALL be low from the cycle after acceptance.
REQ-016 SETUP SHALL last CLK_DIV cycles, with sclk=0 and copi=bit15.
REQ-017 HIGH SHALL last CLK_DIV cycles with sclk=1; after the 16th HIGH the FSM goes to HOLD, otherwise to LOW.
REQ-018 LOW SHALL last CLK_DIV cycles with sclk=0, and copi SHALL advance to the next bit on entry to LOW.
REQ-019 HOLD SHALL last CLK_DIV cycles with sclk=0 and copi held at bit0.
REQ-020 On the HOLD -> GAP transition, ncs SHALL go high and done SHALL pulse for exactly 1 cycle.
REQ-021 GAP SHALL last GAP_CYCLES cycles, then the FSM returns to IDLE.
REQ-022 ncs SHALL be low for exactly 33*CLK_DIV cycles per frame, with exactly 16 sclk rising edges.
REQ-023 sclk, ncs and copi SHALL be driven directly from flops (glitch-free, no combinational outputs).
REQ-024 start while ready=0 SHALL be ignored (not queued).
REQ-025 start held high continuously SHALL produce back-to-back frames separated by GAP_CYCLES+1 cycles of ncs high.
REQ-026 Addresses above 0x04 SHALL be transmitted unchanged; filtering is the peripheral's job.
REQ-027 A single tick counter, width 8 bits, SHALL time all phases; a bit counter, width 4 bits, SHALL count 0..15 with no wrap beyond 15.

Reset
REQ-028 While rst=1: ncs=1, sclk=0, copi=0, done=0, ready=0, FSM=IDLE, and all counters and the shift register = 0.
REQ-029 ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-frame SHALL drive ncs high at the next edge and abort the frame with no done pulse.

Structure
REQ-031 Package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, WRITE_BIT=1, register addresses 0x00..0x04 (EN_OUT_7_0, EN_OUT_15_8, EN_PWM_7_0, EN_PWM_15_8, PWM_DUTY) and the FSM state encoding.
REQ-032 The phase timer SHALL be a sub-module, spi_tick_gen, that produces a one-cycle tick every CLK_DIV cycles while enabled and restarts on each state change.

Verification
REQ-033 CLK_DIV=4, addr=0x04, data=0x80 -> copi bits at rising edges 1,0000100,10000000; ncs low 132 cycles; done pulse once.
REQ-034 Loopback into spi_peripheral, with its reset tied to ~rst -> writes 0x00=0xA5, 0x04=0x3C give en_reg_out_7_0=0xA5 and pwm_duty_cycle=0x3C; other registers stay 0.
REQ-035 start held high with two different frames -> both delivered; ncs high for at least GAP_CYCLES+1 cycles between them.
REQ-036 start pulsed while busy (mid-frame) -> ignored; exactly one frame and one done.
REQ-037 rst asserted after the 5th sclk rise -> ncs=1 next cycle, no done, peripheral registers unchanged; the next frame completes normally.
REQ-038 addr=0x05, data=0xFF -> full 16-bit frame emitted; all peripheral registers unchanged.
